// File: rtl/edge_pkg.sv
// edge_pkg: shared widths, output colours and latency bound for the Sobel edge detector.
package edge_pkg;

   localparam int          LAT_MIN   = 3;
   localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
   localparam logic [23:0] RGB_BLACK = 24'h000000;

   // |Gx|,|Gy| never exceed 4*(2^DW-1), so DW+3 bits cannot overflow.
   function automatic int grad_w(input int dw);
      return dw + 3;
   endfunction

   function automatic int sq_w(input int dw);
      return 2 * grad_w(dw) + 1;
   endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// edge_line_buffer: simple dual-port line RAM, registered read-before-write, enable-gated ports.
module edge_line_buffer #(
   parameter int DW    = 8,
   parameter int DEPTH = 1280
) (
   input  logic                     clk,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [DW-1:0]            i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [DW-1:0]            o_rd_data
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rd_data;

   // NOTE: the array has no reset so it maps onto block RAM; stale contents only
   // ever reach border pixels, which are forced to zero downstream.
   always_ff @(posedge clk) begin
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sobel_edge_detect.sv
// sobel_edge_detect: 3x3 Sobel edge detector with fixed LAT-clock latency, binary output.
// Define EDGE_MAG_OUT_EN to add the Mag_Mode input and the saturated gray-magnitude output.
module sobel_edge_detect
   import edge_pkg::*;
#(
   parameter int DW    = 8,
   parameter int IMG_W = 1280,
   parameter int LAT   = 3
) (
   input  logic          clk_Image_Process,
   input  logic          Rst,
   input  logic          Frame_Start,
   input  logic          RGB_DE,
   input  logic [DW-1:0] Gray_Data,
   input  logic [DW-1:0] Gray_Gate,
`ifdef EDGE_MAG_OUT_EN
   input  logic          Mag_Mode,
`endif
   output logic          Edge_DE,
   output logic [23:0]   RGB_Data,
   output logic [3:0]    Delay_Num
);

   localparam int GW  = grad_w(DW);
   localparam int SW  = sq_w(DW);
   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = 16;
   localparam int PAD = (LAT > 2) ? LAT - 2 : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

   if (LAT < LAT_MIN) begin : g_lat_check
      $error("sobel_edge_detect: LAT must be at least 3");
   end

   logic [CW-1:0] r_col, w_col_cur, w_col_nxt;
   logic [RW-1:0] r_row, w_row_cur, w_row_nxt;
   logic [DW-1:0] r_gate;
   logic [DW-1:0] w_lb1_q, w_lb2_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_col_cur = Frame_Start ? '0 : r_col;
      w_row_cur = Frame_Start ? '0 : r_row;
      w_col_nxt = w_col_cur;
      w_row_nxt = w_row_cur;
      if (RGB_DE) begin
         if (w_col_cur == COL_LAST) begin
            w_col_nxt = '0;
            if (w_row_cur != '1) w_row_nxt = w_row_cur + RW'(1);
         end else begin
            w_col_nxt = w_col_cur + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_Image_Process or negedge Rst) begin
      if (!Rst) begin
         r_col  <= '0;
         r_row  <= '0;
         r_gate <= '0;
      end else begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
         if (Frame_Start) r_gate <= Gray_Gate;
      end
   end

   // Read port prefetches the column the next pixel will land on, so data is ready across DE gaps.
   edge_line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_line1 (
      .clk       (clk_Image_Process),
      .i_wr_en   (RGB_DE),
      .i_wr_addr (w_col_cur),
      .i_wr_data (Gray_Data),
      .i_rd_en   (RGB_DE | Frame_Start),
      .i_rd_addr (w_col_nxt),
      .o_rd_data (w_lb1_q)
   );

   edge_line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_line2 (
      .clk       (clk_Image_Process),
      .i_wr_en   (RGB_DE),
      .i_wr_addr (w_col_cur),
      .i_wr_data (w_lb1_q),
      .i_rd_en   (RGB_DE | Frame_Start),
      .i_rd_addr (w_col_nxt),
      .o_rd_data (w_lb2_q)
   );

   // Window indexed [column][row]; index 2 is the newest column / current row.
   logic [DW-1:0] r_win [3][3];
   logic          r_va, r_border_a;

   always_ff @(posedge clk_Image_Process or negedge Rst) begin
      if (!Rst) begin
         for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) r_win[c][r] <= '0;
         r_va       <= 1'b0;
         r_border_a <= 1'b0;
      end else begin
         r_va <= RGB_DE;
         if (RGB_DE) begin
            r_win[0]    <= r_win[1];
            r_win[1]    <= r_win[2];
            r_win[2][0] <= w_lb2_q;
            r_win[2][1] <= w_lb1_q;
            r_win[2][2] <= Gray_Data;
            r_border_a  <= (w_row_cur < RW'(2)) || (w_col_cur < CW'(2));
         end
      end
   end

   function automatic logic [GW-1:0] abs_diff(input logic [GW-1:0] a, input logic [GW-1:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   logic [GW-1:0] w_gx_p, w_gx_n, w_gy_p, w_gy_n;
   logic [GW-1:0] r_gx, r_gy;
   logic          r_vb, r_border_b;

   always_comb begin
      w_gx_p = GW'(r_win[2][0]) + (GW'(r_win[2][1]) << 1) + GW'(r_win[2][2]);
      w_gx_n = GW'(r_win[0][0]) + (GW'(r_win[0][1]) << 1) + GW'(r_win[0][2]);
      w_gy_p = GW'(r_win[0][2]) + (GW'(r_win[1][2]) << 1) + GW'(r_win[2][2]);
      w_gy_n = GW'(r_win[0][0]) + (GW'(r_win[1][0]) << 1) + GW'(r_win[2][0]);
   end

   always_ff @(posedge clk_Image_Process or negedge Rst) begin
      if (!Rst) begin
         r_gx       <= '0;
         r_gy       <= '0;
         r_vb       <= 1'b0;
         r_border_b <= 1'b0;
      end else begin
         r_gx       <= abs_diff(w_gx_p, w_gx_n);
         r_gy       <= abs_diff(w_gy_p, w_gy_n);
         r_vb       <= r_va;
         r_border_b <= r_border_a;
      end
   end

   logic [SW-1:0] w_sq_sum, w_gate_sq;
   logic [23:0]   w_res;

`ifdef EDGE_MAG_OUT_EN
   localparam logic [GW:0]   MAG_MAX  = (GW+1)'((2 ** DW) - 1);
   localparam logic [DW-1:0] PIX_FULL = DW'((2 ** DW) - 1);
   logic          r_mag_mode;
   logic [GW:0]   w_mag_sum;
   logic [DW-1:0] w_mag_sat;
   logic [7:0]    w_mag8;

   always_ff @(posedge clk_Image_Process or negedge Rst) begin
      if (!Rst)             r_mag_mode <= 1'b0;
      else if (Frame_Start) r_mag_mode <= Mag_Mode;
   end
`endif

   always_comb begin
      w_sq_sum  = SW'(r_gx) * SW'(r_gx) + SW'(r_gy) * SW'(r_gy);
      w_gate_sq = SW'(r_gate) * SW'(r_gate);
      w_res     = RGB_BLACK;
      if (r_vb && !r_border_b && (w_sq_sum > w_gate_sq)) w_res = RGB_WHITE;
`ifdef EDGE_MAG_OUT_EN
      w_mag_sum = (GW+1)'(r_gx) + (GW+1)'(r_gy);
      w_mag_sat = (w_mag_sum > MAG_MAX) ? PIX_FULL : w_mag_sum[DW-1:0];
      // Top 8 bits of the DW-bit magnitude (left-justified when DW < 8).
      w_mag8    = 8'({w_mag_sat, 8'h00} >> DW);
      if (r_vb && !r_border_b && r_mag_mode) w_res = {3{w_mag8}};
`endif
   end

   logic        r_pad_de   [PAD];
   logic [23:0] r_pad_data [PAD];

   always_ff @(posedge clk_Image_Process or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < PAD; i++) begin
            r_pad_de[i]   <= 1'b0;
            r_pad_data[i] <= '0;
         end
      end else begin
         r_pad_de[0]   <= r_vb;
         r_pad_data[0] <= w_res;
         for (int i = 1; i < PAD; i++) begin
            r_pad_de[i]   <= r_pad_de[i-1];
            r_pad_data[i] <= r_pad_data[i-1];
         end
      end
   end

   assign Edge_DE   = r_pad_de[PAD-1];
   assign RGB_Data  = r_pad_data[PAD-1];
   assign Delay_Num = 4'(LAT);

endmodule
